// File: rtl/count_sched_if.sv
// Bundle of the job input, counter drive and result output of count_sched.
// The scheduler itself connects through the slave modport; the surrounding
// logic (job producer, counter stage, result consumer) uses master.
interface count_sched_if #(
  parameter int W     = 8,
  parameter int DEPTH = 4
);
  // job input
  logic                     in_valid;
  logic                     in_ready;
  logic [W-1:0]             in_data;
  logic [1:0]               in_sel;
  // counter stage drive and result
  logic [W-1:0]             cnt_a;
  logic [1:0]               cnt_sel;
  logic                     cnt_start;
  logic                     cnt_done;
  logic [W-1:0]             cnt_out;
  // result output
  logic                     res_valid;
  logic                     res_ready;
  logic [W-1:0]             res_data;
  logic                     res_err;
  // status
  logic                     sel_err;
  logic                     busy;
  logic [$clog2(DEPTH):0]   fifo_count;

  modport slave (
    input  in_valid, in_data, in_sel, cnt_done, cnt_out, res_ready,
    output in_ready, cnt_a, cnt_sel, cnt_start, res_valid, res_data, res_err,
           sel_err, busy, fifo_count
  );

  modport master (
    output in_valid, in_data, in_sel, cnt_done, cnt_out, res_ready,
    input  in_ready, cnt_a, cnt_sel, cnt_start, res_valid, res_data, res_err,
           sel_err, busy, fifo_count
  );
endinterface

// File: rtl/count_sched.sv
// Job scheduler in front of the zero/one counter stage. Jobs are queued in a
// small FIFO, issued one at a time, and each result (or a timeout marker) is
// held on the result port until the consumer takes it.
module count_sched #(
  parameter int W       = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic         clk,
  input  logic         rst,
  count_sched_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t          state_reg, state_next;

  logic [W-1:0]    data_mem [DEPTH];
  logic [1:0]      sel_mem  [DEPTH];
  logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]     count_reg;

  logic [TW-1:0]   tmo_reg;
  logic [W-1:0]    cnt_a_reg;
  logic [1:0]      cnt_sel_reg;
  logic [W-1:0]    res_data_reg;
  logic            res_err_reg;
  logic            sel_err_reg;

  logic            in_ready;
  logic            sel_ok;
  logic            push;
  logic            store;
  logic            pop;
  logic            tmo_hit;

  // DEPTH is a power of two, so "count < DEPTH" is just the count MSB being clear.
  // No bypass when full: a same-cycle pop does not reopen the input.
  assign in_ready = ~count_reg[PW];
  assign sel_ok   = (bus.in_sel == 2'b01) || (bus.in_sel == 2'b10);
  assign push     = bus.in_valid && in_ready;
  // A bad select is still consumed (handshake completes) but never stored.
  assign store    = push && sel_ok;
  assign pop      = (state_reg == IDLE) && (count_reg != '0);
  assign tmo_hit  = (tmo_reg == TW'(TIMEOUT - 1));

  // Job storage: write-only array, read through the registered cnt_a/cnt_sel.
  always_ff @(posedge clk) begin
    if (store) begin
      data_mem[wr_ptr_reg] <= bus.in_data;
      sel_mem[wr_ptr_reg]  <= bus.in_sel;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (store) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)   rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({store, pop})
        2'b10:   count_reg <= count_reg + (PW+1)'(1);
        2'b01:   count_reg <= count_reg - (PW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; cnt_done only matters in WAIT and beats the timeout.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (count_reg != '0) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (bus.cnt_done || tmo_hit) state_next = HOLD;
      HOLD:    if (bus.res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Issue registers, timeout counter and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_a_reg    <= '0;
      cnt_sel_reg  <= '0;
      tmo_reg      <= '0;
      res_data_reg <= '0;
      res_err_reg  <= 1'b0;
    end else begin
      // cnt_a/cnt_sel change only on IDLE->ISSUE and are held afterwards.
      if (pop) begin
        cnt_a_reg   <= data_mem[rd_ptr_reg];
        cnt_sel_reg <= sel_mem[rd_ptr_reg];
      end
      if (state_reg == ISSUE)
        tmo_reg <= '0;
      else if ((state_reg == WAIT) && !bus.cnt_done && !tmo_hit)
        tmo_reg <= tmo_reg + TW'(1);
      if (state_reg == WAIT) begin
        if (bus.cnt_done) begin
          res_data_reg <= bus.cnt_out;
          res_err_reg  <= 1'b0;
        end else if (tmo_hit) begin
          res_data_reg <= '0;
          res_err_reg  <= 1'b1;
        end
      end
    end
  end

  // Sticky flag for dropped jobs with a non-one-hot select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   sel_err_reg <= 1'b0;
    else if (push && !sel_ok)  sel_err_reg <= 1'b1;
  end

  assign bus.in_ready   = in_ready;
  assign bus.cnt_a      = cnt_a_reg;
  assign bus.cnt_sel    = cnt_sel_reg;
  assign bus.cnt_start  = (state_reg == ISSUE);
  assign bus.res_valid  = (state_reg == HOLD);
  assign bus.res_data   = res_data_reg;
  assign bus.res_err    = res_err_reg;
  assign bus.sel_err    = sel_err_reg;
  assign bus.busy       = (state_reg != IDLE) || (count_reg != '0);
  assign bus.fifo_count = count_reg;
endmodule

// File: tb/tb_count_sched.sv
// Directed bench for count_sched with a behavioural counter-stage model.
module tb_count_sched;
  localparam int W       = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 32;

  logic clk;
  logic rst;
  int   checks    = 0;
  int   errors    = 0;
  int   cyc       = 0;
  int   start_cnt = 0;
  int   model_mode  = 0;   // 0: answer after model_delay cycles, 1: never answer
  int   model_delay = 5;
  logic [7:0] model_val;

  count_sched_if #(.W(W), .DEPTH(DEPTH)) bus ();

  count_sched #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (bus.cnt_start === 1'b1) start_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Reference zero/one counter: ones for sel=10, zeros for sel=01.
  function automatic logic [7:0] ref_count(input logic [7:0] a, input logic [1:0] s);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) if (a[i] == (s == 2'b10)) n++;
    return 8'(n);
  endfunction

  // Counter stage model: sees start, waits model_delay cycles, pulses done.
  initial begin
    bus.cnt_done = 1'b0;
    bus.cnt_out  = 8'hEE;
    forever begin
      @(negedge clk);
      if (bus.cnt_start === 1'b1 && model_mode == 0) begin
        model_val = ref_count(bus.cnt_a, bus.cnt_sel);
        repeat (model_delay) @(negedge clk);
        bus.cnt_done = 1'b1;
        bus.cnt_out  = model_val;
        @(negedge clk);
        bus.cnt_done = 1'b0;
        bus.cnt_out  = 8'hEE;
      end
    end
  end

  task automatic push(input logic [7:0] d, input logic [1:0] s, output logic rdy);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sel   = s;
    rdy          = bus.in_ready;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_sel   = 2'b00;
  endtask

  task automatic wait_start(output int c);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.cnt_start !== 1'b1 && n < 100);
    c = cyc;
  endtask

  task automatic wait_valid(output int c);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.res_valid !== 1'b1 && n < 100);
    c = cyc;
  endtask

  task automatic test_reset();
    logic [31:0] outs;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_sel    = 2'b00;
    bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    outs = 32'({bus.cnt_a, bus.cnt_sel, bus.cnt_start, bus.res_valid, bus.res_data,
                bus.res_err, bus.sel_err, bus.busy, bus.fifo_count});
    checks++;
    if (outs !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
    rst = 1'b0;
    $display("reset released at cycle %0d", cyc);
  endtask

  task automatic test_single();
    logic rdy;
    int s0, cs, cv;
    model_mode  = 0;
    model_delay = 5;
    bus.res_ready = 1'b0;
    #1 s0 = start_cnt;
    push(8'hB0, 2'b10, rdy);
    wait_start(cs);
    checks++;
    if (bus.cnt_start !== 1'b1 || bus.cnt_a !== 8'hB0 || bus.cnt_sel !== 2'b10) begin
      errors++;
      $display("FAIL single_issue: got start=%b a=%h sel=%b expected 1 b0 10",
               bus.cnt_start, bus.cnt_a, bus.cnt_sel);
    end
    wait_valid(cv);
    checks++;
    if (bus.res_valid !== 1'b1 || cv - cs != 6) begin
      errors++;
      $display("FAIL single_valid_latency: got valid=%b after %0d cycles expected 1 after 6",
               bus.res_valid, cv - cs);
    end
    checks++;
    if (bus.res_data !== 8'h03 || bus.res_err !== 1'b0 || bus.cnt_a !== 8'hB0) begin
      errors++;
      $display("FAIL single_result: got data=%h err=%b a=%h expected 03 0 b0",
               bus.res_data, bus.res_err, bus.cnt_a);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 8'h03) begin
      errors++;
      $display("FAIL single_hold_stable: got valid=%b data=%h expected 1 03",
               bus.res_valid, bus.res_data);
    end
    #1;
    checks++;
    if (start_cnt - s0 != 1) begin
      errors++;
      $display("FAIL single_start_count: got %0d expected 1", start_cnt - s0);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    checks++;
    if (bus.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_valid_drop: got %b expected 0", bus.res_valid);
    end
    $display("single job a=b0 sel=10 -> data=%h err=%b", bus.res_data, bus.res_err);
  endtask

  task automatic test_queue();
    logic [7:0] jd [5];
    logic [1:0] js [5];
    logic [7:0] ex [5];
    logic [7:0] got_d [5];
    logic       got_e [5];
    logic [4:0] rdy_seen;
    int s0, idx;
    jd[0] = 8'hFF; js[0] = 2'b10; ex[0] = 8'd8;
    jd[1] = 8'h0F; js[1] = 2'b01; ex[1] = 8'd4;
    jd[2] = 8'h01; js[2] = 2'b10; ex[2] = 8'd1;
    jd[3] = 8'h00; js[3] = 2'b01; ex[3] = 8'd8;
    jd[4] = 8'hA5; js[4] = 2'b10; ex[4] = 8'd4;
    model_mode  = 0;
    model_delay = 3;
    bus.res_ready = 1'b0;
    @(negedge clk);
    #1 s0 = start_cnt;
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = jd[c];
      bus.in_sel   = js[c];
      rdy_seen[c]  = bus.in_ready;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    checks++;
    if (rdy_seen !== 5'b11111) begin
      errors++;
      $display("FAIL queue_accept: got ready pattern %b expected 11111", rdy_seen);
    end
    checks++;
    if (bus.in_ready !== 1'b0 || bus.fifo_count !== 3'd4) begin
      errors++;
      $display("FAIL queue_full: got ready=%b count=%0d expected 0 4",
               bus.in_ready, bus.fifo_count);
    end
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 8'd8 || start_cnt - s0 != 1 ||
        bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL queue_stall: got valid=%b data=%0d starts=%0d ready=%b expected 1 8 1 0",
               bus.res_valid, bus.res_data, start_cnt - s0, bus.in_ready);
    end
    bus.res_ready = 1'b1;
    idx = 0;
    for (int n = 0; n < 300 && idx < 5; n++) begin
      if (bus.res_valid === 1'b1) begin
        got_d[idx] = bus.res_data;
        got_e[idx] = bus.res_err;
        $display("queue result %0d data=%0d err=%b", idx, bus.res_data, bus.res_err);
        idx++;
      end
      @(negedge clk);
    end
    bus.res_ready = 1'b0;
    checks++;
    if (idx != 5) begin
      errors++;
      $display("FAIL queue_result_count: got %0d expected 5", idx);
    end
    for (int i = 0; i < idx; i++) begin
      checks++;
      if (got_d[i] !== ex[i] || got_e[i] !== 1'b0) begin
        errors++;
        $display("FAIL queue_order_%0d: got data=%0d err=%b expected %0d 0",
                 i, got_d[i], got_e[i], ex[i]);
      end
    end
    #1;
    checks++;
    if (start_cnt - s0 != 5 || bus.fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL queue_drain: got starts=%0d count=%0d expected 5 0",
               start_cnt - s0, bus.fifo_count);
    end
  endtask

  task automatic test_bad_sel();
    logic r1, r2;
    int s0;
    checks++;
    if (bus.sel_err !== 1'b0) begin
      errors++;
      $display("FAIL bad_sel_initial: got sel_err=%b expected 0", bus.sel_err);
    end
    #1 s0 = start_cnt;
    push(8'h5A, 2'b11, r1);
    push(8'h5A, 2'b00, r2);
    @(negedge clk);
    checks++;
    if (r1 !== 1'b1 || r2 !== 1'b1 || bus.sel_err !== 1'b1 || bus.fifo_count !== 3'd0 ||
        bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL bad_sel_drop: got ready=%b%b sel_err=%b count=%0d busy=%b expected 11 1 0 0",
               r1, r2, bus.sel_err, bus.fifo_count, bus.busy);
    end
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (start_cnt != s0) begin
      errors++;
      $display("FAIL bad_sel_no_start: got %0d starts expected 0", start_cnt - s0);
    end
    $display("bad select jobs 11,00 dropped sel_err=%b", bus.sel_err);
  endtask

  task automatic test_timeout();
    logic rdy;
    int cs, cv;
    bus.res_ready = 1'b1;
    model_mode = 1;
    push(8'h3C, 2'b01, rdy);
    wait_start(cs);
    push(8'hC3, 2'b10, rdy);
    wait_valid(cv);
    checks++;
    if (bus.res_valid !== 1'b1 || cv - cs != 33) begin
      errors++;
      $display("FAIL timeout_latency: got valid=%b after %0d cycles expected 1 after 33",
               bus.res_valid, cv - cs);
    end
    checks++;
    if (bus.res_data !== 8'h00 || bus.res_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_result: got data=%h err=%b expected 00 1", bus.res_data, bus.res_err);
    end
    $display("timeout job a=3c -> data=%h err=%b", bus.res_data, bus.res_err);
    model_mode  = 0;
    model_delay = 4;
    wait_start(cs);
    checks++;
    if (bus.cnt_start !== 1'b1 || bus.cnt_a !== 8'hC3 || bus.cnt_sel !== 2'b10) begin
      errors++;
      $display("FAIL timeout_next_issue: got start=%b a=%h sel=%b expected 1 c3 10",
               bus.cnt_start, bus.cnt_a, bus.cnt_sel);
    end
    wait_valid(cv);
    checks++;
    if (cv - cs != 5 || bus.res_data !== 8'd4 || bus.res_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_next_result: got %0d cycles data=%0d err=%b expected 5 4 0",
               cv - cs, bus.res_data, bus.res_err);
    end
    $display("follow-up job a=c3 -> data=%h err=%b", bus.res_data, bus.res_err);
  endtask

  task automatic test_coincide();
    logic rdy;
    int cs, cv, s0, vseen;
    bus.res_ready = 1'b1;
    model_mode  = 0;
    model_delay = 32;
    push(8'h0F, 2'b10, rdy);
    wait_start(cs);
    wait_valid(cv);
    checks++;
    if (cv - cs != 33 || bus.res_data !== 8'd4 || bus.res_err !== 1'b0) begin
      errors++;
      $display("FAIL coincide_done_wins: got %0d cycles data=%0d err=%b expected 33 4 0",
               cv - cs, bus.res_data, bus.res_err);
    end
    $display("coincident done a=0f -> data=%h err=%b", bus.res_data, bus.res_err);
    model_mode = 1;
    repeat (2) @(negedge clk);
    #1 s0 = start_cnt;
    bus.cnt_done = 1'b1;
    bus.cnt_out  = 8'h55;
    @(negedge clk);
    bus.cnt_done = 1'b0;
    bus.cnt_out  = 8'hEE;
    vseen = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.res_valid !== 1'b0) vseen++;
    end
    #1;
    checks++;
    if (vseen != 0 || bus.busy !== 1'b0 || start_cnt != s0) begin
      errors++;
      $display("FAIL stray_done_idle: got valid_cycles=%0d busy=%b starts=%0d expected 0 0 0",
               vseen, bus.busy, start_cnt - s0);
    end
  endtask

  task automatic test_async_reset();
    logic rdy;
    logic [31:0] outs;
    int cs, cv, s0, vseen;
    bus.res_ready = 1'b1;
    model_mode = 1;
    push(8'h12, 2'b10, rdy);
    wait_start(cs);
    push(8'h34, 2'b10, rdy);
    push(8'h56, 2'b01, rdy);
    @(negedge clk);
    checks++;
    if (bus.fifo_count !== 3'd2 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL areset_setup: got count=%0d busy=%b expected 2 1", bus.fifo_count, bus.busy);
    end
    #2 rst = 1'b1;
    #1;
    outs = 32'({bus.cnt_a, bus.cnt_sel, bus.cnt_start, bus.res_valid, bus.res_data,
                bus.res_err, bus.sel_err, bus.busy, bus.fifo_count});
    checks++;
    if (outs !== 32'h0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL areset_immediate: got outputs=%h ready=%b expected 0 1", outs, bus.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1 s0 = start_cnt;
    vseen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.res_valid !== 1'b0) vseen++;
    end
    #1;
    checks++;
    if (vseen != 0 || start_cnt != s0 || bus.fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL areset_discard: got valid_cycles=%0d starts=%0d count=%0d expected 0 0 0",
               vseen, start_cnt - s0, bus.fifo_count);
    end
    model_mode  = 0;
    model_delay = 4;
    push(8'h81, 2'b01, rdy);
    wait_start(cs);
    checks++;
    if (bus.cnt_start !== 1'b1 || bus.cnt_a !== 8'h81 || bus.cnt_sel !== 2'b01) begin
      errors++;
      $display("FAIL areset_next_issue: got start=%b a=%h sel=%b expected 1 81 01",
               bus.cnt_start, bus.cnt_a, bus.cnt_sel);
    end
    wait_valid(cv);
    checks++;
    if (cv - cs != 5 || bus.res_data !== 8'd6 || bus.res_err !== 1'b0) begin
      errors++;
      $display("FAIL areset_next_result: got %0d cycles data=%0d err=%b expected 5 6 0",
               cv - cs, bus.res_data, bus.res_err);
    end
    $display("post-reset job a=81 sel=01 -> data=%h err=%b", bus.res_data, bus.res_err);
  endtask

  initial begin
    test_reset();
    test_single();
    test_queue();
    test_bad_sel();
    test_timeout();
    test_coincide();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
